// File: rtl/pkt_check_pkg.sv
// Shared types and helpers for the counter-pattern stream checker.
package pkt_check_pkg;

    localparam logic [31:0] PKT_HEADER_DEFAULT = 32'hAABBCCDD;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pkt_check_lane.sv
// One lane of the checker: expected-counter register and mismatch compare.
// PKT_CHECK_ERR_CAPTURE_EN exposes the expected value for first-error capture.
module pkt_check_lane
    import pkt_check_pkg::*;
#(
    parameter int DIN_WIDTH = 32,
    parameter int PARALLEL  = 4,
    parameter int LANE_IDX  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_advance,
    input  logic [DIN_WIDTH-1:0] i_din,
    output logic                 o_mismatch
`ifdef PKT_CHECK_ERR_CAPTURE_EN
    ,
    output logic [DIN_WIDTH-1:0] o_expected
`endif
);

    localparam logic [DIN_WIDTH-1:0] START = DIN_WIDTH'(LANE_IDX);
    localparam logic [DIN_WIDTH-1:0] STEP  = DIN_WIDTH'(PARALLEL);

    logic [DIN_WIDTH-1:0] r_expected;

    // Advances from its own sequence only, so one bad beat never resynchronises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expected <= START;
        end else if (i_clear || i_load) begin
            r_expected <= START;
        end else if (i_advance) begin
            r_expected <= r_expected + STEP;
        end
    end

    assign o_mismatch = (i_din != r_expected);

`ifdef PKT_CHECK_ERR_CAPTURE_EN
    assign o_expected = r_expected;
`endif

endmodule

// File: rtl/pkt_check.sv
// Receive-side checker: hunts headers, verifies counter lanes, keeps statistics.
// PKT_CHECK_ERR_CAPTURE_EN builds the first-mismatch capture registers.
module pkt_check
    import pkt_check_pkg::*;
#(
    parameter int          DIN_WIDTH = 32,
    parameter int          PARALLEL  = 4,
    parameter logic [31:0] HEADER    = PKT_HEADER_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clear,
    input  logic [31:0]                   burst_len,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          din_valid,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   err_count,
    output logic [31:0]                   short_count,
    output logic [31:0]                   orphan_count,
    output logic                          err,
    output logic                          in_pkt,
    output logic [7:0]                    first_err_lane,
    output logic [DIN_WIDTH-1:0]          first_err_exp,
    output logic [DIN_WIDTH-1:0]          first_err_got
);

    localparam logic [DIN_WIDTH-1:0] HDR_LANE = HEADER[DIN_WIDTH-1:0];

    state_t        r_state;
    logic [31:0]   r_len;
    logic [31:0]   r_beat_cnt;
    logic [31:0]   r_pkt;
    logic [31:0]   r_errc;
    logic [31:0]   r_short;
    logic [31:0]   r_orph;
    logic          r_err;

    logic                w_acc;
    logic                w_hdr;
    logic                w_load;
    logic                w_adv;
    logic                w_last;
    logic                w_any_mis;
    logic [PARALLEL-1:0] w_lane_hdr;
    logic [PARALLEL-1:0] w_mis;
`ifdef PKT_CHECK_ERR_CAPTURE_EN
    logic [DIN_WIDTH-1:0] w_exp [PARALLEL];
`endif

    assign w_acc     = din_valid & en;
    assign w_hdr     = &w_lane_hdr;
    assign w_load    = w_acc & w_hdr & ~clear;
    assign w_adv     = w_acc & ~w_hdr & (r_state == PAYLOAD) & ~clear;
    assign w_any_mis = |w_mis;
    assign w_last    = ((r_beat_cnt + 32'd1) == r_len);

    for (genvar i = 0; i < PARALLEL; i++) begin : g_lane
        assign w_lane_hdr[i] = (din[DIN_WIDTH*i +: DIN_WIDTH] == HDR_LANE);

        pkt_check_lane #(
            .DIN_WIDTH (DIN_WIDTH),
            .PARALLEL  (PARALLEL),
            .LANE_IDX  (i)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clear    (clear),
            .i_load     (w_load),
            .i_advance  (w_adv),
            .i_din      (din[DIN_WIDTH*i +: DIN_WIDTH]),
            .o_mismatch (w_mis[i])
`ifdef PKT_CHECK_ERR_CAPTURE_EN
            ,
            .o_expected (w_exp[i])
`endif
        );
    end

    // Clear outranks any beat in the same cycle; the beat is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_pkt      <= '0;
            r_errc     <= '0;
            r_short    <= '0;
            r_orph     <= '0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_state    <= HUNT;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_pkt      <= '0;
            r_errc     <= '0;
            r_short    <= '0;
            r_orph     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_acc) begin
                if (w_hdr) begin
                    if (r_state == PAYLOAD) r_short <= sat_inc(r_short);
                    r_len      <= burst_len;
                    r_beat_cnt <= '0;
                    if (burst_len == 32'd0) begin
                        r_pkt   <= sat_inc(r_pkt);
                        r_state <= HUNT;
                    end else begin
                        r_state <= PAYLOAD;
                    end
                end else if (r_state == HUNT) begin
                    r_orph <= sat_inc(r_orph);
                end else begin
                    if (w_any_mis) begin
                        r_errc <= sat_inc(r_errc);
                        r_err  <= 1'b1;
                    end
                    r_beat_cnt <= r_beat_cnt + 32'd1;
                    if (w_last) begin
                        r_pkt   <= sat_inc(r_pkt);
                        r_state <= HUNT;
                    end
                end
            end
        end
    end

    assign pkt_count    = r_pkt;
    assign err_count    = r_errc;
    assign short_count  = r_short;
    assign orphan_count = r_orph;
    assign err          = r_err;
    assign in_pkt       = (r_state == PAYLOAD);

`ifdef PKT_CHECK_ERR_CAPTURE_EN
    logic                 r_fe_valid;
    logic [7:0]           r_fe_lane;
    logic [DIN_WIDTH-1:0] r_fe_exp;
    logic [DIN_WIDTH-1:0] r_fe_got;
    logic [7:0]           w_fe_lane;
    logic [DIN_WIDTH-1:0] w_fe_exp;
    logic [DIN_WIDTH-1:0] w_fe_got;

    // Scan downwards so the lowest-indexed mismatch wins.
    always_comb begin
        w_fe_lane = '0;
        w_fe_exp  = '0;
        w_fe_got  = '0;
        for (int i = PARALLEL - 1; i >= 0; i--) begin
            if (w_mis[i]) begin
                w_fe_lane = 8'(i);
                w_fe_exp  = w_exp[i];
                w_fe_got  = din[DIN_WIDTH*i +: DIN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fe_valid <= 1'b0;
            r_fe_lane  <= '0;
            r_fe_exp   <= '0;
            r_fe_got   <= '0;
        end else if (clear) begin
            r_fe_valid <= 1'b0;
            r_fe_lane  <= '0;
            r_fe_exp   <= '0;
            r_fe_got   <= '0;
        end else if (w_adv && w_any_mis && !r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_lane  <= w_fe_lane;
            r_fe_exp   <= w_fe_exp;
            r_fe_got   <= w_fe_got;
        end
    end

    assign first_err_lane = r_fe_lane;
    assign first_err_exp  = r_fe_exp;
    assign first_err_got  = r_fe_got;
`else
    assign first_err_lane = '0;
    assign first_err_exp  = '0;
    assign first_err_got  = '0;
`endif

endmodule

// File: tb/tb_pkt_check.sv
// Self-checking bench for pkt_check with a beat-indexed reference model.
// Follows PKT_CHECK_ERR_CAPTURE_EN for the first_err_* expectations.
module tb_pkt_check;

    localparam logic [31:0] HDR = 32'hAABBCCDD;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clear;
    logic [31:0]  burst_len;
    logic [127:0] din;
    logic         din_valid;
    logic [31:0]  pkt_count, err_count, short_count, orphan_count;
    logic         err, in_pkt;
    logic [7:0]   first_err_lane;
    logic [31:0]  first_err_exp, first_err_got;

    logic [31:0]  din8;
    logic         din8_valid;
    logic [31:0]  pkt8, errc8, short8, orph8;
    logic         err8, in_pkt8;
    logic [7:0]   fel8, fee8, feg8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_check #(.DIN_WIDTH(32), .PARALLEL(4), .HEADER(HDR)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .burst_len(burst_len),
        .din(din), .din_valid(din_valid), .pkt_count(pkt_count), .err_count(err_count),
        .short_count(short_count), .orphan_count(orphan_count), .err(err), .in_pkt(in_pkt),
        .first_err_lane(first_err_lane), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    pkt_check #(.DIN_WIDTH(8), .PARALLEL(4), .HEADER(HDR)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .burst_len(burst_len),
        .din(din8), .din_valid(din8_valid), .pkt_count(pkt8), .err_count(errc8),
        .short_count(short8), .orphan_count(orph8), .err(err8), .in_pkt(in_pkt8),
        .first_err_lane(fel8), .first_err_exp(fee8), .first_err_got(feg8)
    );

    // Reference model state: packet progress tracked as a beat index.
    logic [31:0] m_pkt, m_errc, m_short, m_orph, m_len, m_k;
    bit          m_inpkt, m_err_exp, m_fe_valid;
    logic [7:0]  m_fe_lane;
    logic [31:0] m_fe_exp, m_fe_got;
    int          bad_err, bad_inpkt, err_pulses, inpkt_hi;

    function automatic logic [31:0] tsat(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 1;
    endfunction

    function automatic logic [127:0] hdr_beat();
        return {4{HDR}};
    endfunction

    function automatic logic [127:0] pay(input int k);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = 32'(k * 4 + i);
        return d;
    endfunction

    task automatic model_reset();
        m_pkt = 0; m_errc = 0; m_short = 0; m_orph = 0; m_len = 0; m_k = 0;
        m_inpkt = 0; m_err_exp = 0; m_fe_valid = 0; m_fe_lane = 0; m_fe_exp = 0; m_fe_got = 0;
    endtask

    task automatic model_step(input logic [127:0] d, input bit v, input bit e, input bit c,
                              input logic [31:0] bl);
        bit          hdr;
        bit          bad;
        logic [31:0] ev;
        m_err_exp = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (!(v && e)) return;
        hdr = 1;
        for (int i = 0; i < 4; i++) if (d[32*i +: 32] != HDR) hdr = 0;
        if (hdr) begin
            if (m_inpkt) m_short = tsat(m_short);
            if (bl == 0) begin
                m_pkt = tsat(m_pkt);
                m_inpkt = 0;
            end else begin
                m_inpkt = 1; m_len = bl; m_k = 0;
            end
        end else if (!m_inpkt) begin
            m_orph = tsat(m_orph);
        end else begin
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                ev = m_k * 32'd4 + 32'(i);
                if (d[32*i +: 32] != ev) begin
                    if (!m_fe_valid) begin
                        m_fe_valid = 1; m_fe_lane = 8'(i); m_fe_exp = ev; m_fe_got = d[32*i +: 32];
                    end
                    bad = 1;
                end
            end
            if (bad) begin
                m_errc = tsat(m_errc);
                m_err_exp = 1;
            end
            m_k = m_k + 1;
            if (m_k == m_len) begin
                m_pkt = tsat(m_pkt);
                m_inpkt = 0;
            end
        end
    endtask

    task automatic drive(input logic [127:0] d, input bit v, input bit e, input bit c,
                         input logic [31:0] bl);
        @(negedge clk);
        din = d; din_valid = v; en = e; clear = c; burst_len = bl;
        @(posedge clk);
        model_step(d, v, e, c, bl);
        #1;
        if (err !== m_err_exp) bad_err++;
        if (in_pkt !== m_inpkt) bad_inpkt++;
        if (err === 1'b1) err_pulses++;
        if (in_pkt === 1'b1) inpkt_hi++;
    endtask

    task automatic start_test();
        drive('0, 0, 1, 1, 0);
        bad_err = 0; bad_inpkt = 0; err_pulses = 0; inpkt_hi = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, 0, 1, 0, burst_len);
    endtask

    task automatic test_reset();
        checks++; if (pkt_count !== 0) begin errors++; $display("FAIL reset_pkt got %0d exp 0", pkt_count); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
        checks++; if (short_count !== 0) begin errors++; $display("FAIL reset_short got %0d exp 0", short_count); end
        checks++; if (orphan_count !== 0) begin errors++; $display("FAIL reset_orphan got %0d exp 0", orphan_count); end
        checks++; if ({err, in_pkt} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {err, in_pkt}); end
        checks++; if ({first_err_lane, first_err_exp, first_err_got} !== '0) begin
            errors++; $display("FAIL reset_first_err got %0d/%0h/%0h exp 0", first_err_lane, first_err_exp, first_err_got);
        end
    endtask

    task automatic test_clean();
        start_test();
        for (int p = 0; p < 3; p++) begin
            drive(hdr_beat(), 1, 1, 0, 8);
            for (int k = 0; k < 8; k++) drive(pay(k), 1, 1, 0, 8);
            idle(5);
        end
        checks++; if (pkt_count !== 3) begin errors++; $display("FAIL clean_pkt got %0d exp 3", pkt_count); end
        checks++; if ({err_count, short_count, orphan_count} !== '0) begin
            errors++; $display("FAIL clean_stats got %0d/%0d/%0d exp 0/0/0", err_count, short_count, orphan_count);
        end
        checks++; if (inpkt_hi !== 24) begin errors++; $display("FAIL clean_inpkt_cycles got %0d exp 24", inpkt_hi); end
        checks++; if (bad_inpkt !== 0) begin errors++; $display("FAIL clean_inpkt_track got %0d exp 0", bad_inpkt); end
    endtask

    task automatic test_corrupt();
        logic [127:0] d;
        start_test();
        drive(hdr_beat(), 1, 1, 0, 8);
        for (int k = 0; k < 8; k++) begin
            d = pay(k);
            if (k == 3) d[64 +: 32] = 32'hDEAD;
            drive(d, 1, 1, 0, 8);
        end
        idle(2);
        checks++; if (err_count !== 1) begin errors++; $display("FAIL corrupt_errc got %0d exp 1", err_count); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL corrupt_pulses got %0d exp 1", err_pulses); end
        checks++; if (bad_err !== 0) begin errors++; $display("FAIL corrupt_pulse_timing got %0d exp 0", bad_err); end
        checks++; if (pkt_count !== 1) begin errors++; $display("FAIL corrupt_pkt got %0d exp 1", pkt_count); end
`ifdef PKT_CHECK_ERR_CAPTURE_EN
        checks++; if ({first_err_lane, first_err_exp, first_err_got} !== {8'd2, 32'd14, 32'hDEAD}) begin
            errors++; $display("FAIL corrupt_capture got %0d/%0h/%0h exp 2/e/dead", first_err_lane, first_err_exp, first_err_got);
        end
`else
        checks++; if ({first_err_lane, first_err_exp, first_err_got} !== '0) begin
            errors++; $display("FAIL corrupt_capture got %0d/%0h/%0h exp 0", first_err_lane, first_err_exp, first_err_got);
        end
`endif
    endtask

    task automatic test_truncate();
        start_test();
        drive(hdr_beat(), 1, 1, 0, 8);
        for (int k = 0; k < 4; k++) drive(pay(k), 1, 1, 0, 8);
        drive(hdr_beat(), 1, 1, 0, 8);
        for (int k = 0; k < 8; k++) drive(pay(k), 1, 1, 0, 8);
        idle(1);
        checks++; if (short_count !== 1) begin errors++; $display("FAIL trunc_short got %0d exp 1", short_count); end
        checks++; if (pkt_count !== 1) begin errors++; $display("FAIL trunc_pkt got %0d exp 1", pkt_count); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL trunc_err got %0d exp 0", err_count); end
    endtask

    task automatic test_orphans_en();
        start_test();
        for (int n = 0; n < 6; n++) drive({$urandom, $urandom, $urandom, 32'h0}, 1, 1, 0, 8);
        for (int n = 0; n < 6; n++) drive({$urandom, $urandom, $urandom, 32'h0}, 1, 0, 0, 8);
        drive(hdr_beat(), 1, 0, 0, 8);
        checks++; if (orphan_count !== 6) begin errors++; $display("FAIL orphan_count got %0d exp 6", orphan_count); end
        checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL orphan_en_hdr in_pkt got %b exp 0", in_pkt); end
    endtask

    task automatic test_zero_len();
        start_test();
        drive(hdr_beat(), 1, 1, 0, 0);
        checks++; if (pkt_count !== 1) begin errors++; $display("FAIL zero_pkt got %0d exp 1", pkt_count); end
        checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL zero_inpkt got %b exp 0", in_pkt); end
        drive(hdr_beat(), 1, 1, 0, 8);
        drive(pay(0), 1, 1, 0, 8);
        drive(pay(1), 1, 1, 0, 8);
        drive(hdr_beat(), 1, 1, 0, 0);
        checks++; if ({pkt_count, short_count} !== {32'd2, 32'd1}) begin
            errors++; $display("FAIL zero_restart got pkt %0d short %0d exp 2/1", pkt_count, short_count);
        end
        checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL zero_restart_inpkt got %b exp 0", in_pkt); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        start_test();
        @(negedge clk);
        en = 1; clear = 0; burst_len = 70; din_valid = 0;
        din8 = 32'hDDDDDDDD; din8_valid = 1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(k * 4 + i);
            din8 = w;
        end
        @(negedge clk);
        din8_valid = 0;
        @(negedge clk);
        checks++; if (pkt8 !== 1) begin errors++; $display("FAIL wrap_pkt got %0d exp 1", pkt8); end
        checks++; if (errc8 !== 0) begin errors++; $display("FAIL wrap_err got %0d exp 0", errc8); end
        checks++; if (in_pkt8 !== 1'b0) begin errors++; $display("FAIL wrap_inpkt got %b exp 0", in_pkt8); end
    endtask

    task automatic test_reset_clear();
        start_test();
        drive(hdr_beat(), 1, 1, 0, 8);
        for (int k = 0; k < 3; k++) drive(pay(k), 1, 1, 0, 8);
        @(negedge clk);
        din = pay(3); din_valid = 1;
        #2 rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if ({pkt_count, err_count, short_count, orphan_count} !== '0 || in_pkt !== 1'b0) begin
            errors++; $display("FAIL midreset got %0d/%0d/%0d/%0d in_pkt %b exp 0", pkt_count, err_count, short_count, orphan_count, in_pkt);
        end
        @(negedge clk);
        rst_n = 1; din_valid = 0;
        drive(hdr_beat(), 1, 1, 0, 8);
        for (int k = 0; k < 7; k++) drive(pay(k), 1, 1, 0, 8);
        drive(pay(7), 1, 1, 1, 8);
        checks++; if ({pkt_count, err_count, short_count, orphan_count} !== '0 || in_pkt !== 1'b0) begin
            errors++; $display("FAIL midclear got %0d/%0d/%0d/%0d in_pkt %b exp 0", pkt_count, err_count, short_count, orphan_count, in_pkt);
        end
        drive(hdr_beat(), 1, 1, 0, 8);
        for (int k = 0; k < 8; k++) drive(pay(k), 1, 1, 0, 8);
        checks++; if (pkt_count !== 1) begin errors++; $display("FAIL after_clear_pkt got %0d exp 1", pkt_count); end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [31:0]  bl;
        int           r, j;
        bit           v, e, c;
        start_test();
        for (int n = 0; n < 500; n++) begin
            r  = $urandom_range(0, 99);
            c  = (r < 2);
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) != 0);
            bl = 32'($urandom_range(0, 6));
            if (r < 12) begin
                d = hdr_beat();
            end else if (m_inpkt) begin
                d = pay(int'(m_k));
                if ($urandom_range(0, 9) == 0) begin
                    j = $urandom_range(0, 3);
                    d[32*j +: 32] = d[32*j +: 32] ^ (32'($urandom) | 32'd1);
                end
            end else begin
                d = {$urandom, $urandom, $urandom, 32'h0};
            end
            drive(d, v, e, c, bl);
        end
        checks++; if (pkt_count !== m_pkt) begin errors++; $display("FAIL rand_pkt got %0d exp %0d", pkt_count, m_pkt); end
        checks++; if (err_count !== m_errc) begin errors++; $display("FAIL rand_err got %0d exp %0d", err_count, m_errc); end
        checks++; if (short_count !== m_short) begin errors++; $display("FAIL rand_short got %0d exp %0d", short_count, m_short); end
        checks++; if (orphan_count !== m_orph) begin errors++; $display("FAIL rand_orphan got %0d exp %0d", orphan_count, m_orph); end
        checks++; if (bad_err !== 0) begin errors++; $display("FAIL rand_err_pulse got %0d exp 0", bad_err); end
        checks++; if (bad_inpkt !== 0) begin errors++; $display("FAIL rand_inpkt got %0d exp 0", bad_inpkt); end
`ifdef PKT_CHECK_ERR_CAPTURE_EN
        checks++; if ({first_err_lane, first_err_exp, first_err_got} !== {m_fe_lane, m_fe_exp, m_fe_got}) begin
            errors++; $display("FAIL rand_capture got %0d/%0h/%0h exp %0d/%0h/%0h", first_err_lane, first_err_exp, first_err_got, m_fe_lane, m_fe_exp, m_fe_got);
        end
`else
        checks++; if ({first_err_lane, first_err_exp, first_err_got} !== '0) begin
            errors++; $display("FAIL rand_capture got %0d/%0h/%0h exp 0", first_err_lane, first_err_exp, first_err_got);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; en = 0; clear = 0; burst_len = 0; din = '0; din_valid = 0;
        din8 = '0; din8_valid = 0;
        model_reset();
        bad_err = 0; bad_inpkt = 0; err_pulses = 0; inpkt_hi = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        test_reset();
        test_clean();
        test_corrupt();
        test_truncate();
        test_orphans_en();
        test_zero_len();
        test_wrap();
        test_reset_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
